// File: rtl/tensor_core_controller.sv
`default_nettype none
// ============================================================================
// Module   : tensor_core_controller
// Purpose  : Command sequencer for register-file access and tensor-core runs.
// Revision : 1.0 - initial release
// ============================================================================
module tensor_core_controller #(
    parameter int NUMBER_OF_REGISTERS = 32,
    parameter int TIMEOUT_CYCLES      = 64,
    parameter int ADDRESS_WIDTH       = $clog2(NUMBER_OF_REGISTERS)
) (
    input  logic                            clock_in,
    input  logic                            reset_in,
    input  logic                            cmd_valid_in,
    output logic                            cmd_ready_out,
    input  logic [1:0]                      cmd_opcode_in,
    input  logic [ADDRESS_WIDTH-1:0]        cmd_address_in,
    input  logic signed [7:0]               cmd_data_in,
    output logic                            resp_valid_out,
    output logic signed [7:0]               resp_data_out,
    input  logic                            resp_ready_in,
    output logic                            rf_write_enable_out,
    output logic [ADDRESS_WIDTH-1:0]        rf_write_address_out,
    output logic signed [7:0]               rf_write_data_out,
    output logic [ADDRESS_WIDTH-1:0]        rf_read_address_out,
    input  logic signed [7:0]               rf_read_data_in,
    output logic                            rf_bulk_write_enable_out,
    output logic                            tc_start_out,
    input  logic                            tc_done_in,
    output logic                            busy_out,
    output logic                            error_out,
    input  logic                            error_clear_in
);

    localparam int c_count_width = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] c_op_nop     = 2'b00;
    localparam logic [1:0] c_op_write   = 2'b01;
    localparam logic [1:0] c_op_read    = 2'b10;
    localparam logic [1:0] c_op_compute = 2'b11;

    localparam logic [2:0] c_st_idle          = 3'd0;
    localparam logic [2:0] c_st_write         = 3'd1;
    localparam logic [2:0] c_st_read          = 3'd2;
    localparam logic [2:0] c_st_resp          = 3'd3;
    localparam logic [2:0] c_st_compute_start = 3'd4;
    localparam logic [2:0] c_st_compute_wait  = 3'd5;
    localparam logic [2:0] c_st_commit        = 3'd6;

    localparam logic [ADDRESS_WIDTH:0]   c_num_registers = (ADDRESS_WIDTH + 1)'(NUMBER_OF_REGISTERS);
    localparam logic [c_count_width-1:0] c_count_last    = c_count_width'(TIMEOUT_CYCLES - 1);
    localparam logic [c_count_width-1:0] c_count_one     = c_count_width'(1);

    logic [2:0]               r_state;
    logic [2:0]               w_state_next;
    logic [c_count_width-1:0] r_wait_count;
    logic [c_count_width-1:0] w_wait_count_next;
    logic [ADDRESS_WIDTH-1:0] r_cmd_address;
    logic signed [7:0]        r_cmd_data;
    logic                     r_address_ok;

    logic                     r_cmd_ready;
    logic                     r_busy;
    logic                     r_error;
    logic                     r_resp_valid;
    logic signed [7:0]        r_resp_data;
    logic                     r_rf_write_enable;
    logic                     r_bulk_write_enable;
    logic                     r_tc_start;

    logic                     w_cmd_ready_next;
    logic                     w_busy_next;
    logic                     w_error_next;
    logic                     w_resp_valid_next;
    logic signed [7:0]        w_resp_data_next;
    logic                     w_rf_write_enable_next;
    logic                     w_bulk_write_enable_next;
    logic                     w_tc_start_next;

    logic w_handshake;
    logic w_address_ok;
    logic w_timeout;
    logic w_error_set;

    assign w_handshake  = cmd_valid_in & r_cmd_ready;
    assign w_address_ok = ({1'b0, cmd_address_in} < c_num_registers);
    // Done wins over timeout when both land in the last wait cycle.
    assign w_timeout    = (r_state == c_st_compute_wait) & ~tc_done_in & (r_wait_count == c_count_last);
    assign w_error_set  = (w_handshake & ((cmd_opcode_in == c_op_write) | (cmd_opcode_in == c_op_read))
                          & ~w_address_ok) | w_timeout;

    // State register
    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_handshake) begin
                    case (cmd_opcode_in)
                        c_op_write:   w_state_next = c_st_write;
                        c_op_read:    w_state_next = c_st_read;
                        c_op_compute: w_state_next = c_st_compute_start;
                        c_op_nop:     w_state_next = c_st_idle;
                        default:      w_state_next = c_st_idle;
                    endcase
                end
            end
            c_st_write:         w_state_next = c_st_idle;
            c_st_read:          w_state_next = c_st_resp;
            c_st_resp:          if (resp_ready_in) w_state_next = c_st_idle;
            c_st_compute_start: w_state_next = c_st_compute_wait;
            c_st_compute_wait: begin
                if (tc_done_in) begin
                    w_state_next = c_st_commit;
                end else if (r_wait_count == c_count_last) begin
                    w_state_next = c_st_idle;
                end
            end
            c_st_commit:        w_state_next = c_st_idle;
            default:            w_state_next = c_st_idle;
        endcase
    end

    // Output logic: next values for the registered outputs, derived from the
    // state being entered so every strobe is a clean one-cycle flop output.
    always_comb begin
        w_cmd_ready_next         = (w_state_next == c_st_idle);
        w_busy_next              = (w_state_next != c_st_idle);
        w_rf_write_enable_next   = (w_state_next == c_st_write) & (r_state == c_st_idle) & w_address_ok;
        w_tc_start_next          = (w_state_next == c_st_compute_start);
        w_bulk_write_enable_next = (w_state_next == c_st_commit);
        w_resp_valid_next        = (w_state_next == c_st_resp);
        w_error_next             = w_error_set | (r_error & ~error_clear_in);
        w_resp_data_next         = r_resp_data;
        if (r_state == c_st_read) begin
            w_resp_data_next = r_address_ok ? rf_read_data_in : 8'sd0;
        end
        w_wait_count_next = '0;
        if (r_state == c_st_compute_wait) begin
            w_wait_count_next = r_wait_count + c_count_one;
        end
    end

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            r_wait_count        <= '0;
            r_cmd_address       <= '0;
            r_cmd_data          <= '0;
            r_address_ok        <= 1'b0;
            r_cmd_ready         <= 1'b0;
            r_busy              <= 1'b0;
            r_error             <= 1'b0;
            r_resp_valid        <= 1'b0;
            r_resp_data         <= '0;
            r_rf_write_enable   <= 1'b0;
            r_bulk_write_enable <= 1'b0;
            r_tc_start          <= 1'b0;
        end else begin
            r_wait_count        <= w_wait_count_next;
            r_cmd_ready         <= w_cmd_ready_next;
            r_busy              <= w_busy_next;
            r_error             <= w_error_next;
            r_resp_valid        <= w_resp_valid_next;
            r_resp_data         <= w_resp_data_next;
            r_rf_write_enable   <= w_rf_write_enable_next;
            r_bulk_write_enable <= w_bulk_write_enable_next;
            r_tc_start          <= w_tc_start_next;
            if (w_handshake) begin
                r_cmd_address <= cmd_address_in;
                r_cmd_data    <= cmd_data_in;
                r_address_ok  <= w_address_ok;
            end
        end
    end

    assign cmd_ready_out            = r_cmd_ready;
    assign busy_out                 = r_busy;
    assign error_out                = r_error;
    assign resp_valid_out           = r_resp_valid;
    assign resp_data_out            = r_resp_data;
    assign rf_write_enable_out      = r_rf_write_enable;
    assign rf_write_address_out     = r_cmd_address;
    assign rf_write_data_out        = r_cmd_data;
    assign rf_read_address_out      = r_cmd_address;
    assign rf_bulk_write_enable_out = r_bulk_write_enable;
    assign tc_start_out             = r_tc_start;

endmodule
`default_nettype wire

// File: tb/tb_tensor_core_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_tensor_core_controller
// Purpose  : Vector table plus scoreboard bench for tensor_core_controller.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tensor_core_controller;

    localparam int c_aw = 6;

    logic                    clock_in = 1'b0;
    logic                    reset_in;
    logic                    cmd_valid_in;
    logic                    cmd_ready_out;
    logic [1:0]              cmd_opcode_in;
    logic [c_aw-1:0]         cmd_address_in;
    logic signed [7:0]       cmd_data_in;
    logic                    resp_valid_out;
    logic signed [7:0]       resp_data_out;
    logic                    resp_ready_in;
    logic                    rf_write_enable_out;
    logic [c_aw-1:0]         rf_write_address_out;
    logic signed [7:0]       rf_write_data_out;
    logic [c_aw-1:0]         rf_read_address_out;
    logic signed [7:0]       rf_read_data_in;
    logic                    rf_bulk_write_enable_out;
    logic                    tc_start_out;
    logic                    tc_done_in;
    logic                    busy_out;
    logic                    error_out;
    logic                    error_clear_in;

    tensor_core_controller #(
        .NUMBER_OF_REGISTERS(32),
        .TIMEOUT_CYCLES     (64),
        .ADDRESS_WIDTH      (c_aw)
    ) dut (
        .clock_in                (clock_in),
        .reset_in                (reset_in),
        .cmd_valid_in            (cmd_valid_in),
        .cmd_ready_out           (cmd_ready_out),
        .cmd_opcode_in           (cmd_opcode_in),
        .cmd_address_in          (cmd_address_in),
        .cmd_data_in             (cmd_data_in),
        .resp_valid_out          (resp_valid_out),
        .resp_data_out           (resp_data_out),
        .resp_ready_in           (resp_ready_in),
        .rf_write_enable_out     (rf_write_enable_out),
        .rf_write_address_out    (rf_write_address_out),
        .rf_write_data_out       (rf_write_data_out),
        .rf_read_address_out     (rf_read_address_out),
        .rf_read_data_in         (rf_read_data_in),
        .rf_bulk_write_enable_out(rf_bulk_write_enable_out),
        .tc_start_out            (tc_start_out),
        .tc_done_in              (tc_done_in),
        .busy_out                (busy_out),
        .error_out               (error_out),
        .error_clear_in          (error_clear_in)
    );

    always #5 clock_in = ~clock_in;

    // Register-file model behind the DUT ports.
    logic signed [7:0] mem [32] = '{default: 8'sd0};
    always @(posedge clock_in) begin
        if (rf_write_enable_out && rf_write_address_out < 32)
            mem[rf_write_address_out[4:0]] <= rf_write_data_out;
    end
    assign rf_read_data_in = (rf_read_address_out < 32) ? mem[rf_read_address_out[4:0]] : 8'sd0;

    int n_vec = 0;
    int n_err = 0;
    int n_start = 0;
    int n_bulk = 0;

    typedef struct {
        bit                is_resp;
        logic [c_aw-1:0]   addr;
        logic signed [7:0] data;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        logic [1:0]        op;
        logic [c_aw-1:0]   addr;
        logic signed [7:0] data;
        bit                err;
        logic signed [7:0] resp;
    } vec_t;
    vec_t vecs[11];

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock_in);
        #2;
    endtask

    // Issue one command; returns one tick after the handshake edge.
    task automatic send(input logic [1:0] op, input logic [c_aw-1:0] addr,
                        input logic signed [7:0] data, input logic signed [7:0] exp_resp);
        int t = 0;
        while (!cmd_ready_out && t < 200) begin
            tick();
            t++;
        end
        check("cmd_ready_wait", int'(cmd_ready_out), 1);
        if (op == 2'b01 && addr < 32) sb_q.push_back('{1'b0, addr, data});
        if (op == 2'b10) sb_q.push_back('{1'b1, addr, exp_resp});
        cmd_valid_in   = 1'b1;
        cmd_opcode_in  = op;
        cmd_address_in = addr;
        cmd_data_in    = data;
        tick();
        cmd_valid_in  = 1'b0;
        cmd_opcode_in = 2'b00;
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        while ((busy_out || !cmd_ready_out) && t < 300) begin
            tick();
            t++;
        end
        if (busy_out || !cmd_ready_out) check(name, 0, 1);
    endtask

    // Scoreboard monitor, sampled mid-cycle.
    always @(negedge clock_in) begin
        if (!reset_in) begin
            int pulses;
            sb_t e;
            pulses = int'(rf_write_enable_out) + int'(rf_bulk_write_enable_out) + int'(tc_start_out);
            if (pulses != 0) check("pulse_exclusive", pulses, 1);
            if (tc_start_out) n_start++;
            if (rf_bulk_write_enable_out) n_bulk++;
            if (rf_write_enable_out) begin
                if (sb_q.size() == 0 || sb_q[0].is_resp) begin
                    check("unexpected_write", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    check("wr_addr", int'(rf_write_address_out), int'(e.addr));
                    check("wr_data", int'(rf_write_data_out), int'(e.data));
                end
            end
            if (resp_valid_out && resp_ready_in) begin
                if (sb_q.size() == 0 || !sb_q[0].is_resp) begin
                    check("unexpected_resp", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    check("resp_data", int'(resp_data_out), int'(e.data));
                end
            end
        end
    end

    initial begin
        bit exp_err = 1'b0;
        int s0, b0, cnt, bad;

        vecs[0]  = '{2'b01, 6'd5,  -8'sd3,   1'b0, 8'sd0};
        vecs[1]  = '{2'b10, 6'd5,  8'sd0,    1'b0, -8'sd3};
        vecs[2]  = '{2'b00, 6'd5,  8'sd9,    1'b0, 8'sd0};
        vecs[3]  = '{2'b01, 6'd0,  8'sd127,  1'b0, 8'sd0};
        vecs[4]  = '{2'b01, 6'd31, -8'sd128, 1'b0, 8'sd0};
        vecs[5]  = '{2'b10, 6'd0,  8'sd0,    1'b0, 8'sd127};
        vecs[6]  = '{2'b10, 6'd31, 8'sd0,    1'b0, -8'sd128};
        vecs[7]  = '{2'b10, 6'd7,  8'sd0,    1'b0, 8'sd0};
        vecs[8]  = '{2'b01, 6'd32, 8'sd55,   1'b1, 8'sd0};
        vecs[9]  = '{2'b10, 6'd40, 8'sd0,    1'b1, 8'sd0};
        vecs[10] = '{2'b01, 6'd63, 8'sd1,    1'b1, 8'sd0};

        reset_in = 1'b1; cmd_valid_in = 1'b0; cmd_opcode_in = 2'b00;
        cmd_address_in = '0; cmd_data_in = '0; resp_ready_in = 1'b1;
        tc_done_in = 1'b0; error_clear_in = 1'b0;

        repeat (3) tick();
        check("rst_cmd_ready", int'(cmd_ready_out), 0);
        check("rst_busy", int'(busy_out), 0);
        check("rst_error", int'(error_out), 0);
        check("rst_pulses", int'(rf_write_enable_out) + int'(rf_bulk_write_enable_out)
              + int'(tc_start_out) + int'(resp_valid_out), 0);
        reset_in = 1'b0;
        tick();
        check("post_rst_ready", int'(cmd_ready_out), 1);

        for (int i = 0; i < 11; i++) begin
            send(vecs[i].op, vecs[i].addr, vecs[i].data, vecs[i].resp);
            check($sformatf("vec%0d_busy", i), int'(busy_out), int'(vecs[i].op != 2'b00));
            wait_idle($sformatf("vec%0d_idle_timeout", i));
            exp_err = exp_err | vecs[i].err;
            check($sformatf("vec%0d_err", i), int'(error_out), int'(exp_err));
        end
        check("sb_empty_table", sb_q.size(), 0);
        error_clear_in = 1'b1; tick(); error_clear_in = 1'b0;
        check("err_cleared", int'(error_out), 0);

        // Write pulse one cycle after handshake, exactly one cycle wide.
        send(2'b01, 6'd9, 8'sh11, 8'sd0);
        check("wr_latency", int'(rf_write_enable_out), 1);
        tick();
        check("wr_width", int'(rf_write_enable_out), 0);
        // Response two cycles after handshake.
        send(2'b10, 6'd9, 8'sd0, 8'sh11);
        check("rd_lat_early", int'(resp_valid_out), 0);
        tick();
        check("rd_latency", int'(resp_valid_out), 1);
        wait_idle("rd_idle_timeout");

        // Held-off response stays stable.
        resp_ready_in = 1'b0;
        send(2'b10, 6'd5, 8'sd0, -8'sd3);
        tick();
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (!resp_valid_out || resp_data_out != -8'sd3 || cmd_ready_out) bad++;
            tick();
        end
        check("bp_stable", bad, 0);
        resp_ready_in = 1'b1;
        wait_idle("bp_idle_timeout");
        check("sb_empty_bp", sb_q.size(), 0);

        // Compute with done 10 cycles after start.
        s0 = n_start; b0 = n_bulk;
        send(2'b11, 6'd0, 8'sd0, 8'sd0);
        check("tc_start_pulse", int'(tc_start_out), 1);
        repeat (10) tick();
        tc_done_in = 1'b1; tick(); tc_done_in = 1'b0;
        wait_idle("compute_idle_timeout");
        check("compute_starts", n_start - s0, 1);
        check("compute_bulk", n_bulk - b0, 1);
        check("compute_err", int'(error_out), 0);

        // Timeout: error after 64 wait cycles, late done ignored.
        s0 = n_start; b0 = n_bulk;
        send(2'b11, 6'd0, 8'sd0, 8'sd0);
        cnt = 0;
        while (!error_out && cnt < 200) begin
            tick();
            cnt++;
        end
        check("timeout_cycles", cnt, 65);
        check("timeout_ready", int'(cmd_ready_out), 1);
        tc_done_in = 1'b1; tick(); tc_done_in = 1'b0;
        tick();
        check("timeout_bulk", n_bulk - b0, 0);
        check("timeout_busy", int'(busy_out), 0);
        error_clear_in = 1'b1; tick(); error_clear_in = 1'b0;
        check("timeout_err_clear", int'(error_out), 0);

        // Done in the last wait cycle still commits.
        b0 = n_bulk;
        send(2'b11, 6'd0, 8'sd0, 8'sd0);
        repeat (64) tick();
        tc_done_in = 1'b1; tick(); tc_done_in = 1'b0;
        check("edge_done_commit", int'(rf_bulk_write_enable_out), 1);
        check("edge_done_err", int'(error_out), 0);
        wait_idle("edge_idle_timeout");
        check("edge_done_bulk", n_bulk - b0, 1);

        // Error set and clear in the same cycle keeps the error.
        error_clear_in = 1'b1;
        send(2'b01, 6'd32, 8'sd7, 8'sd0);
        error_clear_in = 1'b0;
        check("set_clear_err", int'(error_out), 1);
        wait_idle("set_clear_idle_timeout");

        // Reset mid compute-wait abandons the operation.
        b0 = n_bulk;
        send(2'b11, 6'd0, 8'sd0, 8'sd0);
        repeat (5) tick();
        reset_in = 1'b1;
        #1;
        check("midrst_busy", int'(busy_out), 0);
        check("midrst_err", int'(error_out), 0);
        check("midrst_outs", int'(cmd_ready_out) + int'(resp_valid_out) + int'(rf_write_enable_out)
              + int'(rf_bulk_write_enable_out) + int'(tc_start_out), 0);
        tc_done_in = 1'b1;
        repeat (3) tick();
        tc_done_in = 1'b0;
        reset_in = 1'b0;
        repeat (3) tick();
        check("midrst_bulk", n_bulk - b0, 0);
        check("midrst_idle", int'(busy_out), 0);
        check("midrst_ready", int'(cmd_ready_out), 1);
        check("sb_empty_end", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
